div_iter_sequencer: RTL and testbench

- Sequential restoring-division engine that sits upstream of the divider pipeline. It is the iterative, single-stage variant for area-constrained paths.
- Accepts a dividend/divisor pair over a valid/ready handshake and produces one quotient bit per clock using a shift / compare-subtract / restore step.
- Presents quotient, remainder and a divide-by-zero flag over an output valid/ready handshake.

---
 rtl/div_iter_sequencer.sv | 122 ++++++++++++
 tb/tb_div_iter_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/div_iter_sequencer.sv
// rtl/div_iter_sequencer.sv - iterative restoring divider, one quotient bit per clock
// Optional build macro: DIV_EARLY_EXIT_EN (dividend < divisor finishes right after accept)
module div_iter_sequencer #(
    parameter int DIVISOR_BITS  = 10,
    parameter int DIVIDEND_BITS = 20,
    parameter int CNT_BITS      = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DIVIDEND_BITS-1:0] dividend,
    input  logic [DIVISOR_BITS-1:0]  divisor,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DIVIDEND_BITS-1:0] quotient,
    output logic [DIVISOR_BITS-1:0]  remainder,
    output logic                     dbz
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(DIVIDEND_BITS - 1);

    logic [1:0]               state;
    logic [DIVISOR_BITS-1:0]  dvsr;
    logic [DIVIDEND_BITS-1:0] work_q;
    logic [DIVISOR_BITS:0]    part_r;
    logic [CNT_BITS-1:0]      cnt;

    logic [DIVISOR_BITS:0]    shifted;
    logic [DIVISOR_BITS:0]    trial;
    logic                     no_borrow;
    logic [DIVISOR_BITS:0]    next_r;
    logic [DIVIDEND_BITS-1:0] next_q;
    logic                     accept;
    logic                     unused_bits;

    assign in_ready = (state == ST_IDLE);
    assign accept   = in_valid && in_ready;

    // One restoring step: shift in the next dividend bit, try to subtract the divisor.
    always_comb begin
        shifted   = {part_r[DIVISOR_BITS-1:0], work_q[DIVIDEND_BITS-1]};
        trial     = shifted - {1'b0, dvsr};
        no_borrow = (shifted >= {1'b0, dvsr});
        next_r    = no_borrow ? trial : shifted;
        next_q    = {work_q[DIVIDEND_BITS-2:0], no_borrow};
    end

    // The remainder never exceeds DIVISOR_BITS after a step, so the top bits are spare.
    assign unused_bits = part_r[DIVISOR_BITS] ^ next_r[DIVISOR_BITS];

    // Sequencer: accept operands, iterate, then hold the result until it is consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            dvsr      <= '0;
            work_q    <= '0;
            part_r    <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        dvsr   <= divisor;
                        work_q <= dividend;
                        part_r <= '0;
                        cnt    <= '0;
                        if (divisor == '0) begin
                            // Short path: out_valid follows one edge later from DONE.
                            state     <= ST_DONE;
                            quotient  <= '1;
                            remainder <= '0;
                            dbz       <= 1'b1;
`ifdef DIV_EARLY_EXIT_EN
                        end else if (dividend < DIVIDEND_BITS'(divisor)) begin
                            state     <= ST_DONE;
                            quotient  <= '0;
                            remainder <= dividend[DIVISOR_BITS-1:0];
                            dbz       <= 1'b0;
`endif
                        end else begin
                            state <= ST_CALC;
                            dbz   <= 1'b0;
                        end
                    end
                end
                ST_CALC: begin
                    work_q <= next_q;
                    part_r <= next_r;
                    cnt    <= cnt + CNT_BITS'(1);
                    if (cnt == LAST_CNT) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        quotient  <= next_q;
                        remainder <= next_r[DIVISOR_BITS-1:0];
                    end
                end
                ST_DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter_sequencer.sv
// tb/tb_div_iter_sequencer.sv - scoreboard bench for div_iter_sequencer
module tb_div_iter_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] dividend;
    logic [9:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] quotient;
    logic [9:0]  remainder;
    logic        dbz;

    typedef struct {
        logic [19:0] q;
        logic [9:0]  r;
        logic        z;
        int          lat;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic prev_ov  = 1'b0;

`ifdef DIV_EARLY_EXIT_EN
    localparam int LAT_SMALL = 1;
`else
    localparam int LAT_SMALL = 20;
`endif

    div_iter_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Monitor: compare each newly presented result against the oldest expectation.
    always @(negedge clk) begin
        if (out_valid === 1'b1 && prev_ov !== 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("quotient", quotient, e.q);
                check("remainder", remainder, e.r);
                check("dbz", dbz, e.z);
                check("latency", cyc - e.acc, e.lat);
            end
        end
        prev_ov <= out_valid;
    end

    task automatic issue(input logic [19:0] dd, input logic [9:0] dv);
        int n;
        @(negedge clk);
        dividend = dd;
        divisor  = dv;
        in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("accept_timeout", 1, 0);
    endtask

    task automatic run(input logic [19:0] dd, input logic [9:0] dv, input logic [19:0] eq,
                       input logic [9:0] er, input logic ez, input int lat, input bit hold);
        exp_t e;
        int   n;
        issue(dd, dv);
        e.q = eq; e.r = er; e.z = ez; e.lat = lat; e.acc = cyc + 1;
        exp_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        dividend = 20'hABCDE;
        divisor  = 10'h155;
        n = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            check("result_timeout", 1, 0);
            return;
        end
        if (hold) begin
            for (int i = 0; i < 10; i++) begin
                check("hold_out_valid", out_valid, 1);
                check("hold_quotient", quotient, eq);
                check("hold_remainder", remainder, er);
                check("hold_in_ready", in_ready, 0);
                @(negedge clk);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("pop_out_valid", out_valid, 0);
        check("pop_in_ready", in_ready, 1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_dbz", dbz, 0);

        run(20'd1000,    10'd7,    20'd142,     10'd6, 1'b0, 20, 1'b0);
        run(20'd1048575, 10'd1023, 20'd1025,    10'd0, 1'b0, 20, 1'b0);
        run(20'd1048575, 10'd1,    20'd1048575, 10'd0, 1'b0, 20, 1'b0);
        run(20'd12345,   10'd0,    20'hFFFFF,   10'd0, 1'b1, 1,  1'b0);
        run(20'd500,     10'd9,    20'd55,      10'd5, 1'b0, 20, 1'b1);

        // Abort 1000/7 part-way through; nothing may come out of it.
        issue(20'd1000, 10'd7);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        repeat (25) @(negedge clk);
        check("abort_no_result", out_valid, 0);

        run(20'd99, 10'd10, 20'd9, 10'd9, 1'b0, 20, 1'b0);
        run(20'd5,  10'd9,  20'd0, 10'd5, 1'b0, LAT_SMALL, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
